// File: rtl/io_capture_pkg.sv
// Shared types for the io_capture logic-analyzer slice: FSM state and trigger
// mode encodings plus a small state-decode helper.
package io_capture_pkg;

    localparam int STATE_W     = 3;
    localparam int TRIG_MODE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [TRIG_MODE_W-1:0] {
        TM_LEVEL     = 2'd0,
        TM_RISE      = 2'd1,
        TM_CHANGE    = 2'd2,
        TM_IMMEDIATE = 2'd3
    } trig_mode_e;

    // Capture is in progress (buffer being written) in these states.
    function automatic logic is_busy(input state_e s);
        return (s == ST_FILL) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/io_capture_mem.sv
// DEPTH x WIDTH sample store: one write port, one registered read port.
// Contents are deliberately left unreset.
module io_capture_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: the array has no reset so it can map onto plain storage; consumers
    // qualify the read data with their own reset valid flag instead.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/io_capture_buffer.sv
// On-chip logic analyzer: circular capture of a probe bus around a trigger,
// with PRE pre-trigger samples, followed by a one-sample-per-request readout.
module io_capture_buffer
    import io_capture_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PRE   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [WIDTH-1:0]       probe,
    input  logic [WIDTH-1:0]       trig_mask,
    input  logic [WIDTH-1:0]       trig_value,
    input  logic [TRIG_MODE_W-1:0] trig_mode,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   rd_last,
    output logic                   busy,
    output logic                   done,
    output logic [STATE_W-1:0]     state
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] PRE_A     = AW'(PRE);
    localparam logic [AW-1:0] FILL_LAST = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_LEN  = AW'(DEPTH - PRE - 1);
    localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);

    state_e           r_state;
    logic             r_busy;
    logic             r_done;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_fill_cnt;
    logic [AW-1:0]    r_post_cnt;
    logic [AW-1:0]    r_trig_ptr;
    logic [AW-1:0]    r_rd_cnt;
    logic [WIDTH-1:0] r_probe_prev;
    logic             r_c_prev;
    logic             r_rd_valid;
    logic             r_rd_last;

    trig_mode_e       w_mode;
    logic             w_cond;
    logic             w_trig;
    logic             w_wr_en;
    logic             w_rd_fire;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_mem_q;

    assign w_mode = trig_mode_e'(trig_mode);
    assign w_cond = ((probe ^ trig_value) & trig_mask) == '0;

    always_comb begin
        // NOTE: default assignment first so every path drives w_trig and no latch is inferred.
        w_trig = 1'b0;
        case (w_mode)
            TM_LEVEL:     w_trig = w_cond;
            TM_RISE:      w_trig = w_cond && !r_c_prev;
            TM_CHANGE:    w_trig = ((probe ^ r_probe_prev) & trig_mask) != '0;
            TM_IMMEDIATE: w_trig = 1'b1;
            default:      w_trig = 1'b0;
        endcase
    end

    assign w_wr_en   = !rst && !abort && is_busy(r_state);
    assign w_rd_fire = !rst && !abort && !arm && rd_en && (r_state == ST_DONE);
    // Readout walks the window relative to the trigger slot; AW-bit math wraps.
    assign w_rd_addr = r_trig_ptr - PRE_A + r_rd_cnt;

    io_capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (probe),
        .i_rd_en   (w_rd_fire),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_mem_q)
    );

    // NOTE: every register here uses <= so all of them see pre-edge values of
    // each other; later assignments in the same block override earlier ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_ptr     <= '0;
            r_fill_cnt   <= '0;
            r_post_cnt   <= '0;
            r_trig_ptr   <= '0;
            r_rd_cnt     <= '0;
            r_probe_prev <= '0;
            r_c_prev     <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            r_probe_prev <= probe;
            r_c_prev     <= w_cond;
            r_rd_valid   <= w_rd_fire;
            r_rd_last    <= w_rd_fire && (r_rd_cnt == RD_LAST);
            if (w_rd_fire) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            r_state    <= ST_FILL;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_wr_ptr   <= '0;
                            r_fill_cnt <= '0;
                        end
                    end
                    ST_FILL: begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (r_fill_cnt == FILL_LAST) begin
                            r_state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (w_trig) begin
                            r_trig_ptr <= r_wr_ptr;
                            r_post_cnt <= POST_LEN;
                            r_rd_cnt   <= '0;
                            if (POST_LEN == '0) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        // Counter holds remaining post-trigger writes, this one included.
                        r_post_cnt <= r_post_cnt - 1'b1;
                        if (r_post_cnt == AW'(1)) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state    = r_state;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign rd_data  = r_rd_valid ? w_mem_q : '0;

endmodule

// File: tb/tb_io_capture_buffer.sv
// Self-checking bench for io_capture_buffer: expected read windows are queued
// as each capture is stimulated and popped as rd_valid beats arrive.
module tb_io_capture_buffer;
    import io_capture_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic             abort;
    logic [WIDTH-1:0] probe;
    logic [WIDTH-1:0] trig_mask;
    logic [WIDTH-1:0] trig_value;
    logic [1:0]       trig_mode;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_last;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      checks   = 0;
    int      failures = 0;

    io_capture_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PRE   (PRE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .probe      (probe),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_mode  (trig_mode),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic l);
        rd_exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic start_capture(input logic [1:0] mode, input logic [WIDTH-1:0] mask,
                                 input logic [WIDTH-1:0] value);
        trig_mode  = mode;
        trig_mask  = mask;
        trig_value = value;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    // Drives probe = 0,1,2,... one per cycle until done rises or the budget ends.
    task automatic run_counter_until_done(input string name, input logic [WIDTH-1:0] exp_last);
        logic [WIDTH-1:0] v;
        bit               seen;
        v    = '0;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            probe = v;
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            v = v + 1'b1;
        end
        checks++;
        if (!seen || probe !== exp_last) begin
            failures++;
            $display("FAIL %s done_timing: done=%b after probe=%h, required done=1 after probe=%h",
                     name, done, probe, exp_last);
        end
    endtask

    task automatic read_window(input string name, input int n);
        rd_exp_t e;
        for (int k = 0; k < n + 3; k++) begin
            rd_en = (k < n);
            tick();
            if (rd_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_rd_valid: got data=%h last=%b, required no beat",
                             name, rd_data, rd_last);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e.data || rd_last !== e.last) begin
                        failures++;
                        $display("FAIL %s read_beat: got data=%h last=%b, required data=%h last=%b",
                                 name, rd_data, rd_last, e.data, e.last);
                    end
                end
            end
        end
        rd_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_beats: %0d expected beats never arrived", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== ST_IDLE) begin
            failures++; $display("FAIL reset_state: got %0d, required %0d", state, ST_IDLE);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_busy_done: got busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin
            failures++; $display("FAIL reset_rd_flags: got valid=%b last=%b, required 0 0", rd_valid, rd_last);
        end
        checks++;
        if (rd_data !== '0) begin
            failures++; $display("FAIL reset_rd_data: got %h, required 00", rd_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (state !== ST_IDLE || busy !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle: got state=%0d busy=%b, required 0 0", state, busy);
        end
    endtask

    task automatic test_level();
        start_capture(TM_LEVEL, 8'hFF, 8'h0A);
        checks++;
        if (state !== ST_FILL || busy !== 1'b1) begin
            failures++; $display("FAIL level_arm: got state=%0d busy=%b, required %0d 1", state, busy, ST_FILL);
        end
        run_counter_until_done("level", 8'h15);
        checks++;
        if (state !== ST_DONE || busy !== 1'b0) begin
            failures++; $display("FAIL level_done_state: got state=%0d busy=%b, required %0d 0", state, busy, ST_DONE);
        end
        for (int i = 0; i < DEPTH; i++) begin
            push_exp(8'(8'h06 + i), (i == DEPTH - 1));
        end
        push_exp(8'h06, 1'b0);
        read_window("level", DEPTH + 1);

        // arm beats a simultaneous read request in DONE
        rd_en = 1'b1;
        arm   = 1'b1;
        tick();
        rd_en = 1'b0;
        arm   = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || state !== ST_FILL) begin
            failures++; $display("FAIL arm_over_read: got valid=%b state=%0d, required 0 %0d", rd_valid, state, ST_FILL);
        end
        do_abort();
        checks++;
        if (state !== ST_IDLE) begin
            failures++; $display("FAIL level_cleanup_abort: got state=%0d, required %0d", state, ST_IDLE);
        end
    endtask

    task automatic test_rise();
        logic [WIDTH-1:0] seq [20];
        seq = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09, 8'h0B, 8'h40, 8'h42, 8'h81,
                8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'hCA};
        probe = 8'h01;
        tick();
        start_capture(TM_RISE, 8'h01, 8'h01);
        for (int i = 0; i < 20; i++) begin
            probe = seq[i];
            tick();
            if (i == 5) begin
                checks++;
                if (state !== ST_ARMED) begin
                    failures++; $display("FAIL rise_held_level: got state=%0d, required %0d", state, ST_ARMED);
                end
            end
            if (i == 8) begin
                checks++;
                if (state !== ST_POST) begin
                    failures++; $display("FAIL rise_edge_trigger: got state=%0d, required %0d", state, ST_POST);
                end
            end
        end
        checks++;
        if (done !== 1'b1) begin
            failures++; $display("FAIL rise_done: got done=%b, required 1", done);
        end
        for (int i = 4; i < 20; i++) begin
            push_exp(seq[i], (i == 19));
        end
        read_window("rise", DEPTH);
        do_abort();
    endtask

    task automatic test_change();
        probe = 8'h55;
        tick();
        start_capture(TM_CHANGE, 8'h02, 8'h00);
        for (int i = 0; i < 20; i++) begin
            probe = 8'h55;
            tick();
        end
        probe = 8'h54;
        tick();
        checks++;
        if (state !== ST_ARMED) begin
            failures++; $display("FAIL change_masked_bit: got state=%0d, required %0d", state, ST_ARMED);
        end
        probe = 8'h56;
        tick();
        checks++;
        if (state !== ST_POST) begin
            failures++; $display("FAIL change_trigger: got state=%0d, required %0d", state, ST_POST);
        end
        for (int i = 0; i < DEPTH - PRE - 1; i++) begin
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++; $display("FAIL change_done: got done=%b, required 1", done);
        end
        push_exp(8'h55, 1'b0);
        push_exp(8'h55, 1'b0);
        push_exp(8'h55, 1'b0);
        push_exp(8'h54, 1'b0);
        for (int i = PRE; i < DEPTH; i++) begin
            push_exp(8'h56, (i == DEPTH - 1));
        end
        read_window("change", DEPTH);
        do_abort();
    endtask

    task automatic test_abort_and_immediate();
        start_capture(TM_LEVEL, 8'hFF, 8'h0A);
        for (int i = 0; i <= 8'h0D; i++) begin
            probe = 8'(i);
            tick();
        end
        checks++;
        if (state !== ST_POST) begin
            failures++; $display("FAIL abort_setup_post: got state=%0d, required %0d", state, ST_POST);
        end
        do_abort();
        checks++;
        if (state !== ST_IDLE || done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_to_idle: got state=%0d done=%b busy=%b, required %0d 0 0",
                                 state, done, busy, ST_IDLE);
        end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (rd_valid !== 1'b0) begin
                failures++; $display("FAIL abort_no_read: got rd_valid=%b, required 0", rd_valid);
            end
        end
        rd_en = 1'b0;
        start_capture(TM_IMMEDIATE, 8'h00, 8'h00);
        run_counter_until_done("immediate", 8'h0F);
        for (int i = 0; i < DEPTH; i++) begin
            push_exp(8'(i), (i == DEPTH - 1));
        end
        read_window("immediate", DEPTH);
        do_abort();
    endtask

    task automatic test_no_trigger();
        logic [WIDTH-1:0] v;
        v = '0;
        start_capture(TM_LEVEL, 8'hFF, 8'h01);
        for (int i = 0; i < PRE + 100; i++) begin
            probe = v;
            tick();
            v = v + 1'b1;
        end
        checks++;
        if (state !== ST_ARMED || busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL stay_armed: got state=%0d busy=%b done=%b, required %0d 1 0",
                                 state, busy, done, ST_ARMED);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++; $display("FAIL read_while_armed: got rd_valid=%b, required 0", rd_valid);
        end
        do_abort();
        checks++;
        if (state !== ST_IDLE) begin
            failures++; $display("FAIL armed_abort: got state=%0d, required %0d", state, ST_IDLE);
        end
    endtask

    initial begin
        rst        = 1'b1;
        arm        = 1'b0;
        abort      = 1'b0;
        rd_en      = 1'b0;
        probe      = '0;
        trig_mask  = '0;
        trig_value = '0;
        trig_mode  = 2'd0;
        test_reset();
        test_level();
        test_rise();
        test_change();
        test_abort_and_immediate();
        test_no_trigger();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
